// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: single-request access sequencer for the 32-word SRAM macro.
// Walks each request through SETUP -> ACCESS (ACCESS_CYC cycles) -> HOLD and
// drives the word-line decoder and bit-line strobes from registered outputs.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; the requester holds the request stable until
// that edge, and nothing is accepted or queued while the controller is busy.
// rsp_valid is a single-cycle pulse in HOLD for reads; there is no back-pressure.
module sram_word_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ACCESS_CYC = 2   // word-line enabled cycles, 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [4:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [4:0]        dec_sel,
  output logic              dec_en,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Counter counts down to zero so that zero marks the last ACCESS cycle.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [3:0]          r_cnt;
  logic [4:0]          r_dec_sel;
  logic                r_dec_en;
  logic                r_arr_we;
  logic [DATA_W-1:0]   r_arr_wdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                w_accept;
  logic                w_last_access;

  assign w_accept      = (r_state == S_IDLE) && req_valid;
  assign w_last_access = (r_state == S_ACCESS) && (r_cnt == 4'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; ACCESS exits when the countdown has reached zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid)     w_next = S_SETUP;
      S_SETUP:                     w_next = S_ACCESS;
      S_ACCESS: if (w_last_access) w_next = S_HOLD;
      S_HOLD:                      w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  // Request latch: address and write data are captured only on the accept edge,
  // so dec_sel can never move while the word line is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_dec_sel   <= 5'd0;
      r_arr_wdata <= '0;
    end else if (w_accept) begin
      r_we        <= req_we;
      r_dec_sel   <= req_addr;
      r_arr_wdata <= req_we ? req_wdata : '0;
    end
  end

  // Access countdown: loaded in SETUP, decremented in ACCESS, saturates at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_cnt <= 4'd0;
    else if (r_state == S_SETUP)                     r_cnt <= CNT_LOAD;
    else if (r_state == S_ACCESS && r_cnt != 4'd0)   r_cnt <= r_cnt - 4'd1;
  end

  // Strobes registered from the next state so they are glitch-free and
  // aligned exactly with the ACCESS / HOLD cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_en    <= 1'b0;
      r_arr_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_dec_en    <= (w_next == S_ACCESS);
      r_arr_we    <= (w_next == S_ACCESS) && r_we;
      r_rsp_valid <= (w_next == S_HOLD) && !r_we;
    end
  end

  // Read capture on the edge that closes the last ACCESS cycle, while the
  // word line is still enabled; held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_rsp_rdata <= '0;
    else if (w_last_access && !r_we)   r_rsp_rdata <= arr_rdata;
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign dec_sel   = r_dec_sel;
  assign dec_en    = r_dec_en;
  assign arr_we    = r_arr_we;
  assign arr_wdata = r_arr_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: three instances (ACCESS_CYC = 2, 1, 15) share the
// clock and reset; one is exercised at a time against a per-cycle timeline
// derived from the accept edge and a transaction-level memory model.
module tb_sram_word_ctrl;

  localparam int N = 3;

  function automatic int ac_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  function automatic logic [7:0] seed_val(input int k, input int a);
    if (k == 0 && a == 31) return 8'h3C;
    return 8'((a * 29) + (k * 71) + 17);
  endfunction

  logic       clk;
  logic       rst_n;
  logic       req_valid [N];
  logic       req_ready [N];
  logic       req_we    [N];
  logic [4:0] req_addr  [N];
  logic [7:0] req_wdata [N];
  logic       rsp_valid [N];
  logic [7:0] rsp_rdata [N];
  logic [4:0] dec_sel   [N];
  logic       dec_en    [N];
  logic       arr_we    [N];
  logic [7:0] arr_wdata [N];
  logic [7:0] arr_rdata [N];
  logic       busy      [N];
  logic [1:0] dbg_state [N];

  // Array contents (the SRAM core) and the transaction-level reference.
  logic [7:0] mem     [N][32];
  logic       mem_init;
  logic [7:0] ref_mem [N][32];
  logic [7:0] last_rd [N];
  logic [7:0] exp_q[$];

  int n_chk;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and array model ----------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    sram_word_ctrl #(.DATA_W(8), .ACCESS_CYC(ac_of(g))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_we(req_we[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .dec_sel(dec_sel[g]), .dec_en(dec_en[g]),
      .arr_we(arr_we[g]), .arr_wdata(arr_wdata[g]), .arr_rdata(arr_rdata[g]),
      .busy(busy[g]), .dbg_state(dbg_state[g])
    );
    // Sense amps only present valid data while the word line is enabled.
    assign arr_rdata[g] = dec_en[g] ? mem[g][dec_sel[g]] : 8'hEE;
  end

  initial mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < N; k++)
        for (int a = 0; a < 32; a++) mem[k][a] <= seed_val(k, a);
      mem_init <= 1'b1;
    end else begin
      for (int k = 0; k < N; k++)
        if (arr_we[k] && dec_en[k]) mem[k][dec_sel[k]] <= arr_wdata[k];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int k, input string pfx);
    chk($sformatf("%s k%0d dec_en", pfx, k),    32'(dec_en[k]), 0);
    chk($sformatf("%s k%0d arr_we", pfx, k),    32'(arr_we[k]), 0);
    chk($sformatf("%s k%0d rsp_valid", pfx, k), 32'(rsp_valid[k]), 0);
    chk($sformatf("%s k%0d rsp_rdata", pfx, k), 32'(rsp_rdata[k]), 0);
    chk($sformatf("%s k%0d dec_sel", pfx, k),   32'(dec_sel[k]), 0);
    chk($sformatf("%s k%0d arr_wdata", pfx, k), 32'(arr_wdata[k]), 0);
    chk($sformatf("%s k%0d busy", pfx, k),      32'(busy[k]), 0);
    chk($sformatf("%s k%0d req_ready", pfx, k), 32'(req_ready[k]), 1);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge. Presents one request, waits for ready, then
  // checks every output in each cycle from SETUP through the return to IDLE.
  task automatic do_txn(input int k, input bit we, input logic [4:0] addr,
                        input logic [7:0] wd, input bit keep, output int waited);
    int ac;
    logic [7:0] exp_rd;
    bit in_acc, in_hold, in_idle;
    ac = ac_of(k);
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wd; req_valid[k] = 1'b1;
    waited = 0;
    while (!req_ready[k] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      chk($sformatf("k%0d accept_timeout", k), 32'(waited), 0);
      req_valid[k] = 1'b0;
      return;
    end
    if (we) ref_mem[k][addr] = wd;
    else    exp_q.push_back(ref_mem[k][addr]);
    exp_rd = last_rd[k];
    @(posedge clk);
    #1;
    if (!keep) req_valid[k] = 1'b0;
    for (int c = 1; c <= ac + 3; c++) begin
      @(negedge clk);
      in_acc  = (c >= 2) && (c <= ac + 1);
      in_hold = (c == ac + 2);
      in_idle = (c == ac + 3);
      if (in_hold && !we) begin
        exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        last_rd[k] = exp_rd;
      end
      chk($sformatf("k%0d a%0d c%0d dec_en", k, addr, c),    32'(dec_en[k]), 32'(in_acc));
      chk($sformatf("k%0d a%0d c%0d arr_we", k, addr, c),    32'(arr_we[k]), 32'(in_acc && we));
      chk($sformatf("k%0d a%0d c%0d rsp_valid", k, addr, c), 32'(rsp_valid[k]), 32'(in_hold && !we));
      chk($sformatf("k%0d a%0d c%0d dec_sel", k, addr, c),   32'(dec_sel[k]), 32'(addr));
      chk($sformatf("k%0d a%0d c%0d arr_wdata", k, addr, c), 32'(arr_wdata[k]), we ? 32'(wd) : 0);
      chk($sformatf("k%0d a%0d c%0d rsp_rdata", k, addr, c), 32'(rsp_rdata[k]), 32'(exp_rd));
      chk($sformatf("k%0d a%0d c%0d req_ready", k, addr, c), 32'(req_ready[k]), 32'(in_idle));
      chk($sformatf("k%0d a%0d c%0d busy", k, addr, c),      32'(busy[k]), 32'(!in_idle));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bit we, keep;
    logic [4:0] addr;
    logic [7:0] wd;
    n_chk = 0;
    n_err = 0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 5'd0; req_wdata[k] = 8'd0;
      last_rd[k] = 8'd0;
      for (int a = 0; a < 32; a++) ref_mem[k][a] = seed_val(k, a);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) chk_reset_vals(k, "por");

    // Directed: write 5, read 31, back-to-back read 0 then write 17.
    do_txn(0, 1'b1, 5'd5, 8'hA5, 1'b0, w);
    @(negedge clk);
    do_txn(0, 1'b0, 5'd31, 8'h00, 1'b0, w);
    do_txn(0, 1'b0, 5'd0, 8'h00, 1'b1, w);
    do_txn(0, 1'b1, 5'd17, 8'h5A, 1'b0, w);
    chk("k0 b2b_wait", 32'(w), 0);
    do_txn(0, 1'b0, 5'd17, 8'h00, 1'b0, w);
    do_txn(0, 1'b0, 5'd5, 8'h00, 1'b0, w);

    // Extreme access lengths, then randomized traffic on every instance.
    do_txn(1, 1'b0, 5'd31, 8'h00, 1'b0, w);
    do_txn(2, 1'b0, 5'd0, 8'h00, 1'b0, w);
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 12; i++) begin
        we   = 1'($urandom_range(0, 1));
        addr = 5'($urandom_range(0, 31));
        wd   = 8'($urandom_range(0, 255));
        keep = (i < 11) && ($urandom_range(0, 3) == 0);
        do_txn(k, we, addr, wd, keep, w);
        if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    // Reset in the middle of a write to addr 9: access abandoned, array untouched.
    @(negedge clk);
    req_we[0] = 1'b1; req_addr[0] = 5'd9; req_wdata[0] = 8'hC3; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid pre arr_we", 32'(arr_we[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk_reset_vals(k, "rst_mid");
      last_rd[k] = 8'd0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid post req_ready", 32'(req_ready[0]), 1);
    chk("rst_mid post rsp_valid", 32'(rsp_valid[0]), 0);
    do_txn(0, 1'b0, 5'd9, 8'h00, 1'b0, w);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_word_ctrl.md
# sram_word_ctrl

Sequential access controller for the 32-word SRAM macro. It accepts one read or write request at a time over a valid/ready handshake. It drives the 5-bit word-line select and enable into the 5-to-32 word-line decoder, sequencing setup, access and hold phases, and returns read data with a one-cycle valid pulse. It sits directly upstream of the decoder and the array bit-lines, between the system request port and the SRAM core.

## Interface
Parameters:
- DATA_W, default 8: word width of the array and of the request/response data.
- ACCESS_CYC, default 2: number of cycles the word line is held enabled. Legal range is 1..15; 0 is illegal.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: controller can accept a request; high only in IDLE.
- req_we, input, 1: 1 = write, 0 = read.
- req_addr, input, 5: word address 0..31.
- req_wdata, input, DATA_W: write data.
- rsp_valid, output, 1: one-cycle pulse with read data; never pulses for writes.
- rsp_rdata, output, DATA_W: captured read word; holds its value until the next read capture.
- dec_sel, output, 5: word-line select to the decoder.
- dec_en, output, 1: word-line enable to the decoder.
- arr_we, output, 1: array write strobe.
- arr_wdata, output, DATA_W: bit-line write data.
- arr_rdata, input, DATA_W: sensed bit-line data from the array.
- busy, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_we, req_addr and req_wdata, then go to SETUP. Inputs are ignored at all other times.
- SETUP (1 cycle): dec_sel=latched addr, dec_en=0, arr_we=0. arr_wdata = latched wdata for a write, 0 for a read. Load the access counter with ACCESS_CYC-1. Go to ACCESS.
- ACCESS (ACCESS_CYC cycles): dec_en=1; arr_we=1 for writes only. dec_sel and arr_wdata are stable. The counter decrements each cycle. When the counter reaches 0, go to HOLD; for a read, rsp_rdata<=arr_rdata on that same edge.
- HOLD (1 cycle): dec_en=0, arr_we=0, dec_sel still held. rsp_valid=1 for reads only. Go to IDLE.
- The counter is 4 bits wide and never wraps; it is loaded only in SETUP.
- dec_sel holds the last address in IDLE; it changes only on entry to SETUP.
- dec_en and arr_we are registered outputs, glitch-free. dec_en is never high in SETUP, HOLD or IDLE, so the word line never changes while enabled.

## Timing
- Reset values: req_ready=1 (FSM in IDLE), rsp_valid=0, rsp_rdata=0, dec_sel=0, dec_en=0, arr_we=0, arr_wdata=0, busy=0.
- Accept edge is T, with the FSM in IDLE during cycle T:
  - SETUP occupies cycle T+1.
  - ACCESS occupies cycles T+2 .. T+1+ACCESS_CYC.
  - HOLD occupies cycle T+2+ACCESS_CYC, with rsp_valid high for reads.
  - IDLE returns at T+3+ACCESS_CYC.
- Read latency is ACCESS_CYC+2 cycles from the accept edge to rsp_valid.
- Maximum throughput is one request per ACCESS_CYC+3 cycles.
- req_valid held high continuously is accepted exactly on each IDLE cycle. Requests are never queued or dropped silently; the requester must hold them until ready.
- If rsp_valid is pulsing in HOLD while req_valid is high, no accept happens in that cycle; the accept happens in the following IDLE cycle.
- Address 31 and address 0 need no special handling; there is no wrap or increment.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronous). The in-flight access is abandoned, with no rsp_valid and no further arr_we. After rst_n deasserts, the FSM is in IDLE.

## Test plan
- Reset check: assert rst_n=0 in mid-simulation -> dec_en=0, arr_we=0, rsp_valid=0, rsp_rdata=0, dec_sel=0 immediately, asynchronously, with req_ready=1 after release.
- Single write, ACCESS_CYC=2: req addr=5, wdata=0xA5 at edge T -> dec_sel=5 from T+1; dec_en=1 and arr_we=1 in exactly cycles T+2 and T+3; no rsp_valid; req_ready=1 again at T+5.
- Single read, ACCESS_CYC=2: array model returns 0x3C for addr 31 -> rsp_valid=1 only in cycle T+4 with rsp_rdata=0x3C; arr_we stays 0 throughout.
- Back-to-back: req_valid held high with a read of addr 0 followed by a write to addr 17 -> second accept at T+5; dec_sel changes 0->17 only while dec_en=0.
- ACCESS_CYC=1 and ACCESS_CYC=15: dec_en high for exactly 1 and 15 cycles respectively; read latency is 3 and 17 cycles.
- Reset mid-ACCESS during a write to addr 9 -> arr_we drops at once, no rsp_valid; a following read of addr 9 completes normally with latency ACCESS_CYC+2.
